// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's
// data-memory port and backing memory. Read misses fill a whole line; every store goes through.
module dcache_dm #(
   parameter int unsigned OFFSET_LEN = 2,
   parameter int unsigned INDEX_LEN  = 4
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic        rd_req,
   input  logic [3:0]  wr_be,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int unsigned TAG_LEN = 32 - INDEX_LEN - OFFSET_LEN - 2;
   localparam int unsigned LINES   = 1 << INDEX_LEN;
   localparam int unsigned WORDS   = 1 << OFFSET_LEN;
   localparam int unsigned WA_LEN  = 30;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [LINES-1:0]      r_valid;
   logic [TAG_LEN-1:0]    r_tag  [LINES];
   logic [31:0]           r_data [LINES][WORDS];
   logic [WA_LEN-1:0]     r_lat_wa;
   logic [OFFSET_LEN-1:0] r_fill_cnt;
   logic                  r_mem_req, r_mem_we;
   logic [31:0]           r_mem_addr, r_mem_wdata;
   logic [3:0]            r_mem_be;
   logic [31:0]           r_hit_cnt, r_miss_cnt;

   logic [OFFSET_LEN-1:0] w_offset, w_lat_off, w_fill_inc;
   logic [INDEX_LEN-1:0]  w_index, w_lat_idx;
   logic [TAG_LEN-1:0]    w_tag, w_lat_tag;
   logic                  w_hit, w_lat_hit;
   logic                  w_req_nxt, w_we_nxt;
   logic [31:0]           w_addr_nxt, w_wdata_nxt, w_merged;
   logic [3:0]            w_be_nxt;
   logic                  w_lat_ld, w_fill_start, w_fill_wr, w_fill_last, w_merge;
   logic                  w_hit_inc, w_miss_inc;
   logic                  w_unused_addr;

   assign w_offset   = addr[OFFSET_LEN+1:2];
   assign w_index    = addr[OFFSET_LEN+INDEX_LEN+1:OFFSET_LEN+2];
   assign w_tag      = addr[31:OFFSET_LEN+INDEX_LEN+2];
   assign w_lat_off  = r_lat_wa[OFFSET_LEN-1:0];
   assign w_lat_idx  = r_lat_wa[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
   assign w_lat_tag  = r_lat_wa[WA_LEN-1:OFFSET_LEN+INDEX_LEN];
   assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_lat_hit  = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
   assign w_fill_inc = OFFSET_LEN'(r_fill_cnt + 1'b1);
   assign w_unused_addr = ^addr[1:0];

   assign rd_data   = r_data[w_index][w_offset];
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

   // Store-hit merge: enabled bytes from the outgoing write, the rest from the cached word
   always_comb begin
      w_merged = r_data[w_lat_idx][w_lat_off];
      for (int b = 0; b < 4; b++) begin
         if (r_mem_be[b]) w_merged[8*b +: 8] = r_mem_wdata[8*b +: 8];
      end
   end

   // Next state, stall and next memory-port values
   always_comb begin
      w_state_nxt  = r_state;
      miss         = 1'b0;
      w_req_nxt    = 1'b0;
      w_we_nxt     = 1'b0;
      w_addr_nxt   = '0;
      w_wdata_nxt  = '0;
      w_be_nxt     = '0;
      w_lat_ld     = 1'b0;
      w_fill_start = 1'b0;
      w_fill_wr    = 1'b0;
      w_fill_last  = 1'b0;
      w_merge      = 1'b0;
      w_hit_inc    = 1'b0;
      w_miss_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wr_be != 4'b0000) begin
               miss        = 1'b1;
               w_lat_ld    = 1'b1;
               w_miss_inc  = 1'b1;
               w_state_nxt = S_WRITE;
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = {addr[31:2], 2'b00};
               w_wdata_nxt = wr_data;
               w_be_nxt    = wr_be;
            end else if (rd_req) begin
               if (w_hit) begin
                  w_hit_inc = 1'b1;
               end else begin
                  miss         = 1'b1;
                  w_lat_ld     = 1'b1;
                  w_fill_start = 1'b1;
                  w_miss_inc   = 1'b1;
                  w_state_nxt  = S_FILL;
                  w_req_nxt    = 1'b1;
                  w_addr_nxt   = {w_tag, w_index, {OFFSET_LEN{1'b0}}, 2'b00};
               end
            end
         end
         S_FILL: begin
            miss = 1'b1;
            if (mem_ack) begin
               w_fill_wr = 1'b1;
               if (r_fill_cnt == OFFSET_LEN'(WORDS - 1)) begin
                  w_fill_last = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_req_nxt  = 1'b1;
                  w_addr_nxt = {w_lat_tag, w_lat_idx, w_fill_inc, 2'b00};
               end
            end else begin
               w_req_nxt  = 1'b1;
               w_addr_nxt = r_mem_addr;
            end
         end
         S_WRITE: begin
            miss = 1'b1;
            if (mem_ack) begin
               w_merge     = w_lat_hit;
               w_state_nxt = S_DONE;
            end else begin
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = r_mem_addr;
               w_wdata_nxt = r_mem_wdata;
               w_be_nxt    = r_mem_be;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, valid bits, memory port and counters
   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         r_state     <= S_IDLE;
         r_valid     <= '0;
         r_fill_cnt  <= '0;
         r_lat_wa    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_req   <= w_req_nxt;
         r_mem_we    <= w_we_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_mem_wdata <= w_wdata_nxt;
         r_mem_be    <= w_be_nxt;
         if (w_lat_ld) r_lat_wa <= addr[31:2];
         // The line being refilled stays invisible until its last word lands
         if (w_fill_start) begin
            r_fill_cnt       <= '0;
            r_valid[w_index] <= 1'b0;
         end else if (w_fill_wr) begin
            r_fill_cnt <= w_fill_inc;
         end
         if (w_fill_last) r_valid[w_lat_idx] <= 1'b1;
         if (w_hit_inc && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_miss_inc && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate every use
   always_ff @(posedge CPU_CLK) begin
      if (w_fill_wr) r_data[w_lat_idx][r_fill_cnt] <= mem_rdata;
      if (w_merge) r_data[w_lat_idx][w_lat_off] <= w_merged;
      if (w_fill_last) r_tag[w_lat_idx] <= w_lat_tag;
   end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate data cache placed between the core's MEM/WB data-memory access point and the backing data memory. It supplies the `DCacheMiss` stall signal that the hazard unit currently receives as a constant 0. The core holds its request stable while `miss` is high. On a read miss the block fills a whole line, one word per memory handshake. Every write goes through to memory.

## Interface
Parameters:
- `OFFSET_LEN`, default 2: log2 words per line (4 words).
- `INDEX_LEN`, default 4: log2 number of lines (16 lines).
- `TAG_LEN` is derived, not overridable: 32 − INDEX_LEN − OFFSET_LEN − 2.

Ports:
- `CPU_CLK` in 1: the only clock, rising edge.
- `CPU_RST` in 1: reset, asynchronous, active-high.
- `rd_req` in 1: load request from the core.
- `wr_be` in 4: store byte enables, same encoding as `MemWriteM`. Any nonzero value is a store request.
- `addr` in 32: byte address. Bits [1:0] are ignored.
- `wr_data` in 32: store data, already lane-aligned.
- `rd_data` out 32: hit word, combinational from the data array.
- `miss` out 1: stall request, driven straight to `DCacheMiss`.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 for a write, 0 for a read.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_be` out 4: memory write byte enables.
- `mem_rdata` in 32: memory read data, valid while `mem_ack`=1.
- `mem_ack` in 1: completes the current transaction in the same cycle.
- `hit_cnt` out 32: saturating count of read-hit cycles.
- `miss_cnt` out 32: saturating count of miss events.

## Operation
Address split:
- offset = addr[OFFSET_LEN+1:2]
- index = addr[OFFSET_LEN+INDEX_LEN+1:OFFSET_LEN+2]
- tag = addr[31:32−TAG_LEN]

Storage:
- Per line: 1 valid bit, 1 tag, 2^OFFSET_LEN words, all registers.
- hit = valid[index] && tag match.

FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - Store request (`wr_be`≠0) has priority over `rd_req`: assert `miss`, latch addr, data and be, go to WRITE.
  - `rd_req` with hit: `miss`=0, `rd_data` = line word at offset, `hit_cnt` +1.
  - `rd_req` without hit: assert `miss`, latch tag and index, clear the fill counter, go to FILL.
  - No request: `miss`=0.
- **FILL**
  - `miss`=1, `mem_req`=1, `mem_we`=0.
  - `mem_addr` = {latched tag, latched index, fill counter, 2'b00}.
  - On `mem_ack`: write `mem_rdata` into the word selected by the fill counter, then increment the counter.
  - On the ack of the last word: set the tag, set valid=1, go to IDLE. The held request then hits.
  - Valid stays 0 during the fill, so a partially filled line is never visible.
- **WRITE**
  - `miss`=1, `mem_req`=1, `mem_we`=1, `mem_addr` = latched addr with [1:0]=0, `mem_be` = latched be, `mem_wdata` = latched data.
  - On `mem_ack`: if the line hits, merge the enabled bytes into the cached word; a miss does not allocate. Go to DONE.
- **DONE**
  - `miss`=0 for exactly one cycle, so the core advances past the store. Go to IDLE.
  - This prevents the still-held store from issuing a second write.

Other rules:
- `miss_cnt` +1 on each IDLE→FILL and each IDLE→WRITE transition.
- Both counters saturate at 0xFFFF_FFFF.
- `mem_ack` is ignored in IDLE and DONE.
- `mem_wdata` and `mem_be` are 0 when not in WRITE.

## Timing
Reset values (all reached asynchronously on `CPU_RST`=1, even mid-FILL or mid-WRITE):
- State = IDLE, all valid bits = 0, fill counter = 0.
- `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- `hit_cnt`=0, `miss_cnt`=0.
- `miss` and `rd_data` are combinational from inputs and state. `miss`=1 during reset if a request is present; this is harmless because the core is held in reset.
- A fill interrupted by reset leaves no valid line.

Latencies:
- Read hit: 0 extra cycles.
- Read miss: `miss`=1 for 1 + (cycles to collect N acks), with N = 2^OFFSET_LEN. With `mem_ack` in the same cycle as `mem_req`, that is N+1 cycles (5 by default); the cycle after is a hit.
- Write: `miss`=1 for 1 + (cycles until ack). Minimum is 2 cycles, followed by one DONE cycle with `miss`=0.

Memory handshake:
- `mem_req` and `mem_addr` stay stable until `mem_ack`.
- Back-to-back fill words: `mem_req` stays high and `mem_addr` advances in the cycle after each ack.

## Test plan
- **Reset then cold read.** Release reset, `rd_req`, addr=0x0000_0104, `mem_ack` tied high.
  - `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; `miss` high 5 cycles.
  - Then `rd_data` = word returned for 0x104, `miss_cnt`=1, `hit_cnt`=1.
- **Hit after fill.** Read 0x0000_010C.
  - `miss`=0 in the same cycle, `rd_data` = the fill word for 0x10C, `hit_cnt` increments.
- **Store hit.** `wr_be`=4'b0011, `wr_data`=0xAAAA_BBBB at 0x104 (resident line).
  - One memory write with `mem_be`=0011, then DONE.
  - A subsequent read of 0x104 returns {old[31:16], 16'hBBBB} with no memory traffic.
- **Store miss.** Store to 0x0000_0204, same index, different tag.
  - Memory write issued, line stays tag 0x1.
  - A read of 0x104 still hits.
- **Conflict eviction and slow memory.** Read 0x0000_0200 with `mem_ack` delayed 3 cycles per word.
  - `miss` high 1 + 16 cycles, `mem_addr` stable while waiting.
  - Afterwards 0x104 misses.
- **Reset mid-fill and simultaneous requests.**
  - Assert `CPU_RST` during the 2nd fill word: `mem_req` drops immediately, and a read after release misses.
  - Drive `rd_req` and `wr_be`≠0 together: the WRITE path is taken.
